// File: rtl/phase_sequencer_if.sv
// Handshake bundle between the datapath controller and phase_sequencer:
// run/step/halt/wait requests in, one-hot phase enables and status out.
interface phase_sequencer_if #(
  parameter int RETIRE_W = 32
);
  logic                run;
  logic                step;
  logic                halt_req;
  logic                mem_wait;
  logic [4:0]          phase_en;
  logic                pc_we;
  logic                busy;
  logic                halted;
  logic                step_ack;
  logic [RETIRE_W-1:0] retired;

  modport master (
    output run, step, halt_req, mem_wait,
    input  phase_en, pc_we, busy, halted, step_ack, retired
  );

  modport slave (
    input  run, step, halt_req, mem_wait,
    output phase_en, pc_we, busy, halted, step_ack, retired
  );
endinterface

// File: rtl/phase_sequencer.sv
// Five-phase (IF/ID/EX/MEM/WB) RV32I control sequencer with halt, memory wait and
// retire counting. Single-step support is built only when PHASE_SEQ_STEP_EN is defined.
module phase_sequencer #(
  parameter int RETIRE_W = 32
) (
  input logic               CLK,
  input logic               RST_N,
  phase_sequencer_if.slave  sq
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_IF   = 3'd1,
    S_ID   = 3'd2,
    S_EX   = 3'd3,
    S_MEM  = 3'd4,
    S_WB   = 3'd5
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic                halt_flag_q;
  logic                halt_stop;
  logic                step_edge;
  logic                step_mode_q;
  logic                step_ack_q;
  logic [RETIRE_W-1:0] retired_q;
  logic                wb_to_idle;

  function automatic logic [4:0] phase_of(input state_t s);
    logic [4:0] p;
    p = 5'b00000;
    case (s)
      S_IF:    p = 5'b00001;
      S_ID:    p = 5'b00010;
      S_EX:    p = 5'b00100;
      S_MEM:   p = 5'b01000;
      S_WB:    p = 5'b10000;
      default: p = 5'b00000;
    endcase
    return p;
  endfunction

  // Counter wraps naturally from all-ones back to zero.
  function automatic logic [RETIRE_W-1:0] wrap_inc(input logic [RETIRE_W-1:0] v);
    return v + RETIRE_W'(1);
  endfunction

  // A halt requested during WB itself must still stop at this boundary.
  assign halt_stop  = halt_flag_q | sq.halt_req;
  assign wb_to_idle = (state_q == S_WB) && (state_d == S_IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (sq.run || step_edge) state_d = S_IF;
      S_IF:   if (!sq.mem_wait) state_d = S_ID;
      S_ID:   state_d = S_EX;
      S_EX:   state_d = S_MEM;
      S_MEM:  if (!sq.mem_wait) state_d = S_WB;
      S_WB: begin
        if (sq.run && !halt_stop && !step_mode_q) state_d = S_IF;
        else                                       state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= S_IDLE;
      halt_flag_q <= 1'b0;
      retired_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_d == S_IDLE)
        halt_flag_q <= 1'b0;
      else if ((state_q != S_IDLE) && sq.halt_req)
        halt_flag_q <= 1'b1;
      if (state_q == S_WB)
        retired_q <= wrap_inc(retired_q);
    end
  end

`ifdef PHASE_SEQ_STEP_EN
  logic step_q;

  assign step_edge = sq.step & ~step_q;

  // step_mode records why IDLE was left; run takes precedence and swallows the edge.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      step_q      <= 1'b0;
      step_mode_q <= 1'b0;
      step_ack_q  <= 1'b0;
    end else begin
      step_q     <= sq.step;
      step_ack_q <= wb_to_idle & step_mode_q;
      if ((state_q == S_IDLE) && (state_d == S_IF))
        step_mode_q <= ~sq.run;
      else if (wb_to_idle)
        step_mode_q <= 1'b0;
    end
  end
`else
  logic unused_step;

  assign unused_step = sq.step;
  assign step_edge   = 1'b0;
  assign step_mode_q = 1'b0;
  assign step_ack_q  = 1'b0;
`endif

  // Moore outputs decoded from the state register only.
  always_comb begin
    sq.phase_en = phase_of(state_q);
    sq.pc_we    = (state_q == S_WB);
    sq.busy     = (state_q != S_IDLE);
    sq.halted   = (state_q == S_IDLE);
  end

  assign sq.step_ack = step_ack_q;
  assign sq.retired  = retired_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Self-checking bench for phase_sequencer: vector table, directed corner sequences
// and randomized traffic against a phase-counting reference model.
module tb_phase_sequencer;

  logic clk;
  logic rst_n;

  phase_sequencer_if #(.RETIRE_W(32)) sq ();
  phase_sequencer_if #(.RETIRE_W(4))  sq4 ();

  phase_sequencer #(.RETIRE_W(32)) dut  (.CLK(clk), .RST_N(rst_n), .sq(sq));
  phase_sequencer #(.RETIRE_W(4))  dut4 (.CLK(clk), .RST_N(rst_n), .sq(sq4));

  assign sq4.run      = sq.run;
  assign sq4.step     = sq.step;
  assign sq4.halt_req = sq.halt_req;
  assign sq4.mem_wait = sq.mem_wait;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model: m_ph is 0 for idle, 1..5 for IF..WB.
  int          m_ph;
  bit          m_halt;
  bit          m_stepping;
  bit          m_ack;
  bit          m_sq;
  int unsigned m_ret;

`ifdef PHASE_SEQ_STEP_EN
  localparam bit STEP_EN = 1'b1;
`else
  localparam bit STEP_EN = 1'b0;
`endif

  typedef struct {
    bit          run;
    bit          step;
    bit          halt;
    bit          mw;
    logic [4:0]  ph;
    int unsigned ret;
  } vec_t;

  vec_t vec[15];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ph = 0; m_halt = 0; m_stepping = 0; m_ack = 0; m_sq = 0; m_ret = 0;
  endtask

  task automatic model_clock(input bit r, input bit s, input bit h, input bit w);
    bit edge_s;
    int nph;
    bit nack;
    edge_s = STEP_EN && s && !m_sq;
    m_sq   = s;
    nph    = m_ph;
    nack   = 0;
    if (m_ph == 0) begin
      if (r)           begin nph = 1; m_stepping = 0; end
      else if (edge_s) begin nph = 1; m_stepping = 1; end
    end else if (m_ph == 1 || m_ph == 4) begin
      nph = w ? m_ph : m_ph + 1;
    end else if (m_ph == 5) begin
      m_ret = m_ret + 1;
      if (r && !m_halt && !h && !m_stepping) nph = 1;
      else begin
        nph = 0;
        nack = m_stepping;
        m_stepping = 0;
      end
    end else begin
      nph = m_ph + 1;
    end
    if (nph == 0)                 m_halt = 0;
    else if (m_ph != 0 && h)      m_halt = 1;
    m_ph  = nph;
    m_ack = nack;
  endtask

  task automatic check_all();
    logic [4:0] eph;
    logic [3:0] r4;
    eph = (m_ph == 0) ? 5'd0 : 5'(1 << (m_ph - 1));
    r4  = m_ret[3:0];
    chk("phase_en", sq.phase_en, eph);
    chk("pc_we/busy/halted", {sq.pc_we, sq.busy, sq.halted},
        {(m_ph == 5), (m_ph != 0), (m_ph == 0)});
    chk("step_ack", sq.step_ack, m_ack);
    chk("retired", sq.retired, m_ret);
    chk("retired4", sq4.retired, r4);
  endtask

  task automatic apply(input bit r, input bit s, input bit h, input bit w);
    sq.run = r; sq.step = s; sq.halt_req = h; sq.mem_wait = w;
    @(posedge clk);
    model_clock(r, s, h, w);
    #1;
    check_all();
  endtask

  initial begin
    // run, step, halt, mem_wait, expected phase_en, expected retired
    vec[0]  = '{1, 0, 0, 0, 5'h01, 0};
    vec[1]  = '{1, 0, 0, 0, 5'h02, 0};
    vec[2]  = '{1, 0, 0, 0, 5'h04, 0};
    vec[3]  = '{1, 0, 0, 0, 5'h08, 0};
    vec[4]  = '{1, 0, 0, 0, 5'h10, 0};
    vec[5]  = '{1, 0, 0, 0, 5'h01, 1};
    vec[6]  = '{1, 0, 0, 0, 5'h02, 1};
    vec[7]  = '{1, 0, 0, 0, 5'h04, 1};
    vec[8]  = '{1, 0, 0, 0, 5'h08, 1};
    vec[9]  = '{1, 0, 0, 1, 5'h08, 1};
    vec[10] = '{1, 0, 0, 1, 5'h08, 1};
    vec[11] = '{1, 0, 0, 1, 5'h08, 1};
    vec[12] = '{1, 0, 0, 0, 5'h10, 1};
    vec[13] = '{0, 0, 0, 0, 5'h00, 2};
    vec[14] = '{0, 0, 0, 0, 5'h00, 2};

    rst_n = 1'b0;
    sq.run = 0; sq.step = 0; sq.halt_req = 0; sq.mem_wait = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_phase_en", sq.phase_en, 5'd0);
    chk("reset_flags", {sq.pc_we, sq.busy, sq.halted, sq.step_ack}, 4'b0010);
    chk("reset_retired", sq.retired, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Free-run, then a 3-cycle memory wait in MEM, then run drops in WB.
    for (int i = 0; i < 15; i++) begin
      apply(vec[i].run, vec[i].step, vec[i].halt, vec[i].mw);
      chk($sformatf("tbl%0d_phase", i), sq.phase_en, vec[i].ph);
      chk($sformatf("tbl%0d_retired", i), sq.retired, vec[i].ret);
    end

    // One-cycle halt during ID with run held: finish, idle one cycle, then restart.
    apply(1, 0, 0, 0);
    apply(1, 0, 0, 0);
    chk("halt_in_id", sq.phase_en, 5'h02);
    apply(1, 0, 1, 0);
    apply(1, 0, 0, 0);
    apply(1, 0, 0, 0);
    chk("halt_wb", sq.phase_en, 5'h10);
    apply(1, 0, 0, 0);
    chk("halt_halted", sq.halted, 1'b1);
    chk("halt_retired", sq.retired, 32'd3);
    apply(1, 0, 0, 0);
    chk("halt_restart", sq.phase_en, 5'h01);
    repeat (5) apply(0, 0, 0, 0);
    chk("halt_drain", sq.retired, 32'd4);

    // Single step with a second pulse during EX that must be dropped.
    apply(0, 1, 0, 0);
    chk("step_if", sq.phase_en, STEP_EN ? 5'h01 : 5'h00);
    apply(0, 0, 0, 0);
    apply(0, 0, 0, 0);
    apply(0, 1, 0, 0);
    apply(0, 0, 0, 0);
    chk("step_wb", sq.pc_we, STEP_EN);
    apply(0, 0, 0, 0);
    chk("step_ack_pulse", sq.step_ack, STEP_EN);
    chk("step_idle", sq.halted, 1'b1);
    apply(0, 0, 0, 0);
    chk("step_ack_clear", sq.step_ack, 1'b0);
    chk("step_retired", sq.retired, STEP_EN ? 32'd5 : 32'd4);

    // Run and a step edge together: run wins, no acknowledge afterwards.
    apply(1, 1, 0, 0);
    repeat (5) apply(0, 0, 0, 0);
    chk("run_step_no_ack", sq.step_ack, 1'b0);

    // Asynchronous reset in the middle of EX.
    repeat (3) apply(1, 0, 0, 0);
    chk("pre_reset_ex", sq.phase_en, 5'h04);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_phase_en", sq.phase_en, 5'd0);
    chk("async_rst_busy", sq.busy, 1'b0);
    chk("async_rst_retired", sq.retired, 32'd0);
    model_reset();
    sq.run = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // Sixteen free-run instructions wrap the 4-bit counter back to zero.
    repeat (80) apply(1, 0, 0, 0);
    apply(0, 0, 0, 0);
    chk("wrap_retired4", sq4.retired, 4'd0);
    chk("wrap_retired32", sq.retired, 32'd16);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      apply(($urandom_range(0, 9) < 7), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
